// File: rtl/updown_step_counter.sv
// rtl/updown_step_counter.sv - up/down counter with variable step, wrap or saturate at MAX, and load
// Flags are registered one-cycle pulses that line up with the count update; tc is combinational.
module updown_step_counter #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned MAX   = 2**WIDTH - 1,
  parameter bit          SAT   = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic [WIDTH-1:0] step,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             carry,
  output logic             borrow,
  output logic             err,
  output logic             tc
);

  localparam logic [WIDTH-1:0] MAX_W   = WIDTH'(MAX);
  localparam logic [WIDTH:0]   MAX_EXT = (WIDTH+1)'(MAX);
  localparam logic [WIDTH:0]   MOD_EXT = MAX_EXT + 1'b1;

  logic [WIDTH-1:0] count_q, count_d;
  logic             carry_q, carry_d;
  logic             borrow_q, borrow_d;
  logic             err_q, err_d;

  logic [WIDTH:0] cnt_ext;
  logic [WIDTH:0] step_ext;
  logic [WIDTH:0] load_ext;
  logic [WIDTH:0] sum_ext;
  logic [WIDTH:0] short_ext;

  always_comb begin
    cnt_ext   = {1'b0, count_q};
    step_ext  = {1'b0, step};
    load_ext  = {1'b0, load_val};
    sum_ext   = cnt_ext + step_ext;
    // How far below zero a down step would land; only meaningful when step > count.
    short_ext = step_ext - cnt_ext;

    count_d  = count_q;
    carry_d  = 1'b0;
    borrow_d = 1'b0;
    err_d    = 1'b0;

    if (load) begin
      if (load_ext > MAX_EXT) begin
        count_d = MAX_W;
        err_d   = 1'b1;
      end else begin
        count_d = load_val;
      end
    end else if (en) begin
      if (step_ext > MAX_EXT) begin
        err_d = 1'b1;
      end else if (up) begin
        if (sum_ext > MAX_EXT) begin
          carry_d = 1'b1;
          count_d = SAT ? MAX_W : WIDTH'(sum_ext - MOD_EXT);
        end else begin
          count_d = WIDTH'(sum_ext);
        end
      end else begin
        if (step_ext > cnt_ext) begin
          borrow_d = 1'b1;
          count_d  = SAT ? '0 : WIDTH'(MOD_EXT - short_ext);
        end else begin
          count_d = WIDTH'(cnt_ext - step_ext);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q  <= '0;
      carry_q  <= 1'b0;
      borrow_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      count_q  <= count_d;
      carry_q  <= carry_d;
      borrow_q <= borrow_d;
      err_q    <= err_d;
    end
  end

  assign count  = count_q;
  assign carry  = carry_q;
  assign borrow = borrow_q;
  assign err    = err_q;
  assign tc     = up ? (count_q == MAX_W) : (count_q == '0);

endmodule

// File: tb/tb_updown_step_counter.sv
// tb/tb_updown_step_counter.sv - directed bench: wrap and saturate at MAX=9, wrap at MAX=15
module tb_updown_step_counter;

  logic       clk;
  logic       rst;
  logic       en;
  logic       up;
  logic [3:0] step;
  logic       load;
  logic [3:0] load_val;

  logic [3:0] w_count, s_count, p_count;
  logic       w_carry, s_carry, p_carry;
  logic       w_borrow, s_borrow, p_borrow;
  logic       w_err, s_err, p_err;
  logic       w_tc, s_tc, p_tc;

  int errors = 0;
  int checks = 0;

  updown_step_counter #(.WIDTH(4), .MAX(9), .SAT(1'b0)) u_wrap (
    .clk(clk), .rst(rst), .en(en), .up(up), .step(step), .load(load), .load_val(load_val),
    .count(w_count), .carry(w_carry), .borrow(w_borrow), .err(w_err), .tc(w_tc)
  );

  updown_step_counter #(.WIDTH(4), .MAX(9), .SAT(1'b1)) u_sat (
    .clk(clk), .rst(rst), .en(en), .up(up), .step(step), .load(load), .load_val(load_val),
    .count(s_count), .carry(s_carry), .borrow(s_borrow), .err(s_err), .tc(s_tc)
  );

  updown_step_counter #(.WIDTH(4), .MAX(15), .SAT(1'b0)) u_pow2 (
    .clk(clk), .rst(rst), .en(en), .up(up), .step(step), .load(load), .load_val(load_val),
    .count(p_count), .carry(p_carry), .borrow(p_borrow), .err(p_err), .tc(p_tc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [3:0] v);
    load = 1'b1; en = 1'b0; load_val = v;
    cyc();
    load = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; up = 1'b0; step = '0; load = 1'b0; load_val = '0;
    #2;
    check("rst_count", w_count, 0);
    check("rst_flags", {w_carry, w_borrow, w_err}, 0);
    check("rst_tc_down", w_tc, 1);
    @(negedge clk);
    rst = 1'b0;

    // wrap overflow with carry, saturate overflow, pow2 no overflow
    do_load(4'd8);
    check("load8", w_count, 8);
    en = 1'b1; up = 1'b1; step = 4'd3;
    cyc();
    check("wrap_up_count", w_count, 1);
    check("wrap_up_carry", w_carry, 1);
    check("sat_up_count", s_count, 9);
    check("sat_up_carry", s_carry, 1);
    check("pow2_up_count", p_count, 11);
    check("pow2_up_carry", p_carry, 0);
    en = 1'b0;
    cyc();
    check("hold_count", w_count, 1);
    check("hold_carry", w_carry, 0);

    // underflow in all three, then exact landing on MAX
    do_load(4'd1);
    en = 1'b1; up = 1'b0; step = 4'd3;
    cyc();
    check("wrap_dn_count", w_count, 8);
    check("wrap_dn_borrow", w_borrow, 1);
    check("sat_dn_count", s_count, 0);
    check("sat_dn_borrow", s_borrow, 1);
    check("pow2_dn_count", p_count, 14);
    check("pow2_dn_borrow", p_borrow, 1);
    up = 1'b1; step = 4'd1;
    cyc();
    check("land_max_count", w_count, 9);
    check("land_max_flags", {w_carry, w_borrow, w_err}, 0);
    check("land_max_tc", w_tc, 1);
    check("pow2_land_count", p_count, 15);
    check("pow2_land_tc", p_tc, 1);
    check("sat_tc_low", s_tc, 0);

    // saturate underflow from 2 by 5
    do_load(4'd2);
    en = 1'b1; up = 1'b0; step = 4'd5;
    cyc();
    check("sat_dn2_count", s_count, 0);
    check("sat_dn2_borrow", s_borrow, 1);
    check("wrap_dn2_count", w_count, 7);
    check("pow2_dn2_count", p_count, 13);

    // out-of-range load wins over en
    load = 1'b1; en = 1'b1; up = 1'b1; step = 4'd1; load_val = 4'd12;
    cyc();
    check("ld12_count", w_count, 9);
    check("ld12_err", w_err, 1);
    check("ld12_carry", w_carry, 0);
    check("pow2_ld12_count", p_count, 12);
    check("pow2_ld12_err", p_err, 0);
    load_val = 4'd4;
    cyc();
    check("ld4_count", w_count, 4);
    check("ld4_err", w_err, 0);
    load = 1'b0;

    // illegal step, then zero step
    do_load(4'd5);
    en = 1'b1; up = 1'b1; step = 4'd10;
    cyc();
    check("step10_count", w_count, 5);
    check("step10_flags", {w_carry, w_borrow, w_err}, 3'b001);
    check("pow2_step10_count", p_count, 15);
    check("pow2_step10_flags", {p_carry, p_borrow, p_err}, 0);
    step = 4'd0;
    cyc();
    check("step0_count", w_count, 5);
    check("step0_flags", {w_carry, w_borrow, w_err}, 0);

    // exact landing on zero
    do_load(4'd3);
    en = 1'b1; up = 1'b0; step = 4'd3;
    cyc();
    check("land0_count", w_count, 0);
    check("land0_flags", {w_carry, w_borrow, w_err}, 0);
    check("land0_tc", w_tc, 1);

    // async reset between edges with count=7 and err pending
    do_load(4'd7);
    en = 1'b1; up = 1'b1; step = 4'd10;
    cyc();
    check("pre_rst_err", w_err, 1);
    check("pre_rst_count", w_count, 7);
    #3 rst = 1'b1;
    #1;
    check("async_rst_count", w_count, 0);
    check("async_rst_flags", {w_carry, w_borrow, w_err}, 0);
    step = 4'd2;
    cyc();
    check("held_rst_count", w_count, 0);
    #2 rst = 1'b0;
    cyc();
    check("resume_count", w_count, 2);
    check("resume_flags", {w_carry, w_borrow, w_err}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
